// File: rtl/fullyconn_nxm_dbuf.sv
`default_nettype none
// ============================================================================
//  Module   : fullyconn_nxm_dbuf
//  Brief    : NUM_IN x NUM_OUT crossbar cell with scan-loaded shadow config
//             and atomic commit to the active route selection.
//  Revision : 1.0 - initial release
// ============================================================================
module fullyconn_nxm_dbuf #(
    parameter int WIDTH   = 32,
    parameter int NUM_IN  = 17,
    parameter int NUM_OUT = 1,
    parameter int REG_OUT = 1
) (
    input  logic                       config_clk,
    input  logic                       config_reset,
    input  logic                       config_en,
    input  logic                       config_in,
    output logic                       config_out,
    input  logic                       config_load,
    input  logic [NUM_IN*WIDTH-1:0]    in_data,
    input  logic [NUM_IN-1:0]          in_valid,
    output logic [NUM_OUT*WIDTH-1:0]   out_data,
    output logic [NUM_OUT-1:0]         out_valid
);

    localparam int SEL_W   = $clog2(NUM_IN);
    localparam int FLD_W   = SEL_W + 1;
    localparam int CHAIN_L = NUM_OUT * FLD_W;

    logic [CHAIN_L-1:0]       r_shadow;
    logic [CHAIN_L-1:0]       r_active;
    logic [NUM_OUT*WIDTH-1:0] w_data;
    logic [NUM_OUT-1:0]       w_valid;

    // Load samples the pre-shift shadow, so a simultaneous shift never leaks in.
    always_ff @(posedge config_clk) begin
        if (!config_reset) begin
            r_shadow <= '0;
            r_active <= '0;
        end else begin
            if (config_en)
                r_shadow <= {config_in, r_shadow[CHAIN_L-1:1]};
            if (config_load)
                r_active <= r_shadow;
        end
    end

    assign config_out = r_shadow[0];

    for (genvar j = 0; j < NUM_OUT; j++) begin : g_sel
        logic             w_en;
        logic [SEL_W-1:0] w_sel;
        logic [WIDTH-1:0] w_d;
        logic             w_v;

        assign w_en  = r_active[j*FLD_W + FLD_W - 1];
        assign w_sel = r_active[j*FLD_W +: SEL_W];

        // Out-of-range selects match no channel and fall through to zero.
        always_comb begin
            w_d = '0;
            w_v = 1'b0;
            if (w_en) begin
                for (int i = 0; i < NUM_IN; i++) begin
                    if (w_sel == SEL_W'(i)) begin
                        w_d = in_data[i*WIDTH +: WIDTH];
                        w_v = in_valid[i];
                    end
                end
            end
        end

        assign w_data[j*WIDTH +: WIDTH] = w_d;
        assign w_valid[j]               = w_v;
    end

    if (REG_OUT != 0) begin : g_reg_out
        always_ff @(posedge config_clk) begin
            if (!config_reset) begin
                out_data  <= '0;
                out_valid <= '0;
            end else begin
                out_data  <= w_data;
                out_valid <= w_valid;
            end
        end
    end else begin : g_comb_out
        assign out_data  = w_data;
        assign out_valid = w_valid;
    end

endmodule
`default_nettype wire

// File: tb/tb_fullyconn_nxm_dbuf.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fullyconn_nxm_dbuf
//  Brief    : Directed bench for the crossbar cell; registered and
//             combinational variants share one config stream and inputs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fullyconn_nxm_dbuf;

    localparam int WIDTH   = 32;
    localparam int NUM_IN  = 17;
    localparam int NUM_OUT = 2;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      cfg_en;
    logic                      cfg_in;
    logic                      cfg_load;
    logic [NUM_IN*WIDTH-1:0]   in_data;
    logic [NUM_IN-1:0]         in_valid;
    logic                      cfg_out_r, cfg_out_c;
    logic [NUM_OUT*WIDTH-1:0]  out_data_r, out_data_c;
    logic [NUM_OUT-1:0]        out_valid_r, out_valid_c;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fullyconn_nxm_dbuf #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT), .REG_OUT(1)) dut_reg (
        .config_clk(clk), .config_reset(rst_n), .config_en(cfg_en), .config_in(cfg_in),
        .config_out(cfg_out_r), .config_load(cfg_load), .in_data(in_data), .in_valid(in_valid),
        .out_data(out_data_r), .out_valid(out_valid_r)
    );

    fullyconn_nxm_dbuf #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT), .REG_OUT(0)) dut_comb (
        .config_clk(clk), .config_reset(rst_n), .config_en(cfg_en), .config_in(cfg_in),
        .config_out(cfg_out_c), .config_load(cfg_load), .in_data(in_data), .in_valid(in_valid),
        .out_data(out_data_c), .out_valid(out_valid_c)
    );

    typedef struct {
        logic [5:0]  f0;
        logic [5:0]  f1;
        logic [16:0] ival;
        logic [31:0] d0;
        logic        v0;
        logic [31:0] d1;
        logic        v1;
    } vec_t;

    vec_t vecs[6];

    // Output snapshots packed as {d1, v1, d0, v0}
    function automatic logic [65:0] snap_r();
        return {out_data_r[63:32], out_valid_r[1], out_data_r[31:0], out_valid_r[0]};
    endfunction

    function automatic logic [65:0] snap_c();
        return {out_data_c[63:32], out_valid_c[1], out_data_c[31:0], out_valid_c[0]};
    endfunction

    function automatic logic [65:0] pack_exp(logic [31:0] d0, logic v0, logic [31:0] d1, logic v1);
        return {d1, v1, d0, v0};
    endfunction

    task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Shifts w LSB first, recording config_out before each shift edge.
    task automatic shift_word(input logic [11:0] w, output logic [11:0] seen);
        for (int k = 0; k < 12; k++) begin
            seen[k] = cfg_out_r;
            cfg_en  = 1'b1;
            cfg_in  = w[k];
            tick();
        end
        cfg_en = 1'b0;
        cfg_in = 1'b0;
    endtask

    task automatic do_load();
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
    endtask

    task automatic set_channels();
        for (int i = 0; i < NUM_IN; i++)
            in_data[i*WIDTH +: WIDTH] = 32'hA5A5_0000 | 32'(i);
        in_data[3*WIDTH +: WIDTH]  = 32'hDEAD_BEEF;
        in_data[16*WIDTH +: WIDTH] = 32'h1234_5678;
    endtask

    logic [11:0] seen;
    logic [11:0] old_w;
    logic [11:0] wa;
    logic [65:0] e;
    logic [31:0] bv[3];

    initial begin
        vecs[0] = '{6'b1_00011, 6'b1_10000, 17'h00008, 32'hDEAD_BEEF, 1'b1, 32'h1234_5678, 1'b0};
        vecs[1] = '{6'b1_11111, 6'b0_00101, 17'h1FFFF, 32'h0,         1'b0, 32'h0,         1'b0};
        vecs[2] = '{6'b1_00000, 6'b1_00000, 17'h00001, 32'hA5A5_0000, 1'b1, 32'hA5A5_0000, 1'b1};
        vecs[3] = '{6'b1_01001, 6'b1_10001, 17'h1FFFF, 32'hA5A5_0009, 1'b1, 32'h0,         1'b0};
        vecs[4] = '{6'b1_00101, 6'b0_10000, 17'h00020, 32'hA5A5_0005, 1'b1, 32'h0,         1'b0};
        vecs[5] = '{6'b1_10000, 6'b1_00011, 17'h10000, 32'h1234_5678, 1'b1, 32'hDEAD_BEEF, 1'b0};
        bv[0] = 32'h0BAD_F00D;
        bv[1] = 32'h5555_AAAA;
        bv[2] = 32'hFFFF_0001;

        // Reset with noisy inputs
        rst_n    = 1'b0;
        cfg_en   = 1'b0;
        cfg_in   = 1'b0;
        cfg_load = 1'b0;
        in_valid = '1;
        for (int i = 0; i < NUM_IN; i++)
            in_data[i*WIDTH +: WIDTH] = $urandom;
        tick();
        tick();
        chk("reset_out_reg", snap_r(), '0);
        chk("reset_out_comb", snap_c(), '0);
        chk("reset_cfg_out", {65'd0, cfg_out_r}, '0);
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        chk("post_reset_reg", snap_r(), '0);
        chk("post_reset_comb", snap_c(), '0);

        // Table-driven routes
        set_channels();
        for (int v = 0; v < 6; v++) begin
            in_valid = vecs[v].ival;
            shift_word({vecs[v].f1, vecs[v].f0}, seen);
            do_load();
            #1;
            e = pack_exp(vecs[v].d0, vecs[v].v0, vecs[v].d1, vecs[v].v1);
            chk($sformatf("vec%0d_comb", v), snap_c(), e);
            tick();
            chk($sformatf("vec%0d_reg", v), snap_r(), e);

            // Broadcast of in0: combinational tracks same cycle, registered one edge later
            if (v == 2) begin
                for (int b = 0; b < 3; b++) begin
                    in_data[31:0] = bv[b];
                    #1;
                    chk($sformatf("bcast%0d_comb", b), snap_c(), pack_exp(bv[b], 1'b1, bv[b], 1'b1));
                    tick();
                    chk($sformatf("bcast%0d_reg", b), snap_r(), pack_exp(bv[b], 1'b1, bv[b], 1'b1));
                end
                in_data[31:0] = 32'hA5A5_0000;
            end
        end

        // Shadow isolation: route from the basic test stays live while shifting
        set_channels();
        in_valid = 17'h00008;
        old_w    = {6'b1_10000, 6'b1_00011};
        shift_word(old_w, seen);
        do_load();
        tick();
        e = pack_exp(32'hDEAD_BEEF, 1'b1, 32'h1234_5678, 1'b0);
        chk("iso_start", snap_r(), e);
        for (int k = 0; k < 12; k++) begin
            chk($sformatf("iso_cfg_out%0d", k), {65'd0, cfg_out_r}, {65'd0, old_w[k]});
            cfg_en = 1'b1;
            cfg_in = (12'b1_00000_100101 >> k) & 1'b1;
            tick();
            chk($sformatf("iso_hold%0d", k), snap_r(), e);
        end
        cfg_en = 1'b0;
        chk("iso_comb_hold", snap_c(), e);
        in_valid = 17'h00021;
        do_load();
        #1;
        e = pack_exp(32'hA5A5_0005, 1'b1, 32'hA5A5_0000, 1'b1);
        chk("iso_new_comb", snap_c(), e);
        chk("iso_new_reg_lag", snap_r(), pack_exp(32'hDEAD_BEEF, 1'b0, 32'h1234_5678, 1'b0));
        tick();
        chk("iso_new_reg", snap_r(), e);

        // Simultaneous shift and load: active takes the pre-shift shadow
        wa       = {6'b1_00000, 6'b1_01001};
        in_valid = 17'h00201;
        shift_word(wa, seen);
        cfg_en   = 1'b1;
        cfg_in   = 1'b1;
        cfg_load = 1'b1;
        tick();
        cfg_en   = 1'b0;
        cfg_load = 1'b0;
        e = pack_exp(32'hA5A5_0009, 1'b1, 32'hA5A5_0000, 1'b1);
        chk("simul_comb", snap_c(), e);
        chk("simul_shifted", {65'd0, cfg_out_r}, {65'd0, wa[1]});
        tick();
        chk("simul_reg", snap_r(), e);

        // Reset mid-shift after 7 bits discards the partial config
        for (int k = 0; k < 7; k++) begin
            cfg_en = 1'b1;
            cfg_in = 1'b1;
            tick();
        end
        rst_n = 1'b0;
        tick();
        rst_n  = 1'b1;
        cfg_en = 1'b0;
        chk("midrst_cfg_out", {65'd0, cfg_out_r}, '0);
        chk("midrst_reg", snap_r(), '0);
        chk("midrst_comb", snap_c(), '0);
        do_load();
        tick();
        chk("midrst_empty_load", snap_r(), '0);
        in_valid = 17'h10008;
        shift_word({6'b1_00011, 6'b1_10000}, seen);
        chk("midrst_shadow_zero", {54'd0, seen}, '0);
        do_load();
        tick();
        chk("midrst_reload", snap_r(), pack_exp(32'h1234_5678, 1'b1, 32'hDEAD_BEEF, 1'b1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fullyconn_nxm_dbuf.md
Name: fullyconn_nxm_dbuf

Overview:
- Parametrised N-input × M-output crossbar switch cell for the CGRA routing fabric.
- Each output independently selects one input, or is disabled.
- Configuration arrives on a serial scan chain into a shadow register, and a `config_load` pulse commits it atomically to the active selection. Reconfiguration therefore never glitches live routes.
- Inputs carry data plus valid. Outputs are optionally registered, with valid propagated.

Parameters:
- WIDTH, 32, data width per channel.
- NUM_IN, 17, number of input channels (≥2).
- NUM_OUT, 1, number of output channels (≥1).
- REG_OUT, 1, 1 = registered outputs (1-cycle latency), 0 = combinational outputs.
- Derived: SEL_W = clog2(NUM_IN).
- Derived: FLD_W = SEL_W+1 (bit FLD_W-1 = enable, low SEL_W bits = select).
- Derived: CHAIN_L = NUM_OUT*FLD_W.

Ports:
- config_clk  in  1  sole clock; datapath and config chain.
- config_reset  in  1  synchronous, active-low reset.
- config_en  in  1  shift enable for the shadow chain.
- config_in  in  1  serial config bit.
- config_out  out  1  serial config out, equal to shadow[0]; cascades to the next cell.
- config_load  in  1  commit pulse, shadow → active.
- in_data  in  NUM_IN*WIDTH  packed inputs; channel i occupies [i*WIDTH +: WIDTH].
- in_valid  in  NUM_IN  per-input valid.
- out_data  out  NUM_OUT*WIDTH  packed outputs; channel j occupies [j*WIDTH +: WIDTH].
- out_valid  out  NUM_OUT  per-output valid.

Behaviour:
- Reset (config_reset=0 at a rising edge):
  - shadow and active both clear to 0, so all outputs are disabled.
  - out_data, out_valid and config_out are 0.
  - With REG_OUT=0, outputs are 0 combinationally while active=0.
  - Reset has priority over shift, load and datapath updates, including mid-shift; partially shifted config is discarded.
- Shift:
  - On each edge with config_en=1: shadow <= {config_in, shadow[CHAIN_L-1:1]}.
  - config_out = shadow[0], a registered bit.
  - After CHAIN_L enabled cycles, the first bit shifted in sits at shadow[0].
  - Field j = shadow[j*FLD_W +: FLD_W].
  - config_en=0 holds shadow.
- Load:
  - On an edge with config_load=1: active <= shadow.
  - If config_en and config_load are both 1, active takes the pre-shift shadow value and shadow still shifts.
  - A load with unchanged shadow is harmless.
- Selection for output j: en = active field bit FLD_W-1, sel = low SEL_W bits.
  - en=0 → data 0, valid 0.
  - en=1 and sel<NUM_IN → data = in_data[sel], valid = in_valid[sel].
  - en=1 and sel≥NUM_IN → data 0, valid 0 (illegal select; must not assert or X-propagate).
- REG_OUT=1:
  - out_data/out_valid register the selection result every edge, with no stall.
  - Latency is 1 cycle from input to output.
  - After a load at edge t, the new route is visible on outputs after edge t+1.
- REG_OUT=0:
  - Outputs are purely combinational from active and inputs.
  - The new route is visible immediately after the load edge.
- Output independence: multiple outputs may select the same input (broadcast). No arbitration is needed.
- Shadow contents never affect outputs until loaded.

Test Plan (NUM_IN=17, NUM_OUT=2, WIDTH=32, REG_OUT=1; FLD_W=6, CHAIN_L=12):
1. Reset:
   - Stimulus: hold config_reset=0 for 2 cycles with in_data driven to random values and all in_valid=1.
   - Response: out_data=0, out_valid=2'b00, config_out=0. Releasing reset, with no load, keeps the outputs 0.
2. Basic route:
   - Stimulus: shift in 12 bits so that field0=6'b1_00011 (in3) and field1=6'b1_10000 (in16), then pulse config_load. Drive in3=0xDEADBEEF/valid=1 and in16=0x12345678/valid=0.
   - Response: one cycle after the load takes effect, out0=0xDEADBEEF/valid=1 and out1=0x12345678/valid=0.
3. Shadow isolation:
   - Stimulus: with the route from test 2 active, shift a new pattern for 12 cycles with no load.
   - Response: outputs are unchanged throughout. After config_load, the new routes appear 1 cycle later.
   - Also check config_out emits the old shadow bits in order, LSB first.
4. Illegal and disabled selects:
   - Stimulus: load field0=6'b1_11111 (sel 31 ≥17) and field1=6'b0_00101.
   - Response: both outputs hold data 0 and valid 0 regardless of inputs.
5. Simultaneous events:
   - Stimulus (a): assert config_en and config_load in the same cycle. Response: active equals the pre-shift shadow.
   - Stimulus (b): assert config_reset=0 mid-shift at bit 7, then release. Response: shadow=0, and subsequent 12-bit loads work correctly.
6. Broadcast / REG_OUT=0 variant:
   - Stimulus: both fields select in0. Response: both outputs mirror in0 each cycle.
   - Rerun with REG_OUT=0. Response: outputs follow in0 changes in the same cycle, with zero latency.
